// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-port and stream handshake bundle between asyn_fifo, fifo_rd_stream_adapter and the downstream sink.
// The master modport is the adapter side; the slave modport is its environment (FIFO read port and stream sink).
interface fifo_rd_stream_adapter_if #(
  parameter int DSIZE = 8
);
  logic             O_rinc;
  logic             I_rempty;
  logic [DSIZE-1:0] I_rdata;
  logic             O_tvalid;
  logic             I_tready;
  logic [DSIZE-1:0] O_tdata;
  logic             O_tlast;

  modport master (
    output O_rinc,
    input  I_rempty,
    input  I_rdata,
    output O_tvalid,
    input  I_tready,
    output O_tdata,
    output O_tlast
  );

  modport slave (
    input  O_rinc,
    output I_rempty,
    output I_rdata,
    input  O_tvalid,
    output I_tready,
    input  O_tdata,
    input  O_tlast
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Pops asyn_fifo words into a 2-entry skid buffer and presents them as a valid/ready stream with O_tlast framing.
// Optional sequence checker enabled by defining FIFO_RD_SEQ_CHK_EN.
module fifo_rd_stream_adapter #(
  parameter int DSIZE     = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic                    I_rclk,
  input  logic                    I_rrst,
  fifo_rd_stream_adapter_if.master bus,
  output logic [1:0]              O_level,
  output logic                    O_seq_err
);
  localparam int FCW = $clog2(FRAME_LEN + 1);
  localparam logic [FCW-1:0] LAST_BEAT = FCW'(FRAME_LEN - 1);

  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic [1:0]       level_q, level_d;
  logic             inflight_q, inflight_d;
  logic [FCW-1:0]   count_q, count_d;
  logic             tvalid;
  logic             fire;
  logic             rinc;
  logic [1:0]       level_after_fire;

  assign tvalid = (level_q != 2'd0);
  assign fire   = tvalid & bus.I_tready;

  always_comb begin
    // Words already held plus the one arriving this cycle, minus the one leaving, must stay below 2.
    rinc = ~I_rrst & ~bus.I_rempty &
           (({1'b0, level_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, fire}));
    inflight_d       = rinc;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    level_after_fire = level_q - {1'b0, fire};
    if (fire) begin
      head_d  = tail_q;
      count_d = (count_q == LAST_BEAT) ? '0 : count_q + 1'b1;
    end
    if (inflight_q) begin
      if (level_after_fire == 2'd0) head_d = bus.I_rdata;
      else                          tail_d = bus.I_rdata;
    end
    level_d = level_after_fire + {1'b0, inflight_q};
  end

  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= 2'd0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  assign bus.O_rinc   = rinc;
  assign bus.O_tvalid = tvalid;
  assign bus.O_tdata  = head_q;
  assign bus.O_tlast  = tvalid & (count_q == LAST_BEAT);
  assign O_level      = level_q;

`ifdef FIFO_RD_SEQ_CHK_EN
  logic [DSIZE-1:0] expect_q, expect_d;
  logic             seq_err_q, seq_err_d;

  // Every captured word must be one more than the previous capture; the first expected word is 1.
  always_comb begin
    expect_d  = expect_q;
    seq_err_d = seq_err_q;
    if (inflight_q) begin
      if (bus.I_rdata != expect_q) seq_err_d = 1'b1;
      expect_d = bus.I_rdata + 1'b1;
    end
  end

  always_ff @(posedge I_rclk) begin
    if (I_rrst) begin
      expect_q  <= DSIZE'(1);
      seq_err_q <= 1'b0;
    end else begin
      expect_q  <= expect_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign O_seq_err = seq_err_q;
`else
  assign O_seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: queue-based FIFO and stream reference model, directed scenarios then random traffic.
module tb_fifo_rd_stream_adapter;
  localparam int DSIZE = 8;
  localparam int FL    = 8;
`ifdef FIFO_RD_SEQ_CHK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level;
  logic       seq_err;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter_if #(.DSIZE(DSIZE)) bus ();

  fifo_rd_stream_adapter #(.DSIZE(DSIZE), .FRAME_LEN(FL)) dut (
    .I_rclk   (clk),
    .I_rrst   (rst),
    .bus      (bus),
    .O_level  (level),
    .O_seq_err(seq_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: FIFO contents, word on the read bus, words held by the adapter.
  logic [7:0] fifo_q[$];
  logic [7:0] held_q[$];
  bit         pend_v;
  logic [7:0] pend_w;
  int         beat;
  logic [7:0] exp_seq;
  bit         err_m;
  int         cyc;
  int         fires;
  int         rinc_first, rinc_last, rinc_cnt, tv_first, tv_last, tv_cnt;
  logic [7:0] next_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rinc_first = -1; rinc_last = -1; rinc_cnt = 0;
    tv_first = -1; tv_last = -1; tv_cnt = 0; fires = 0;
  endtask

  task automatic cycle(input bit rs, input bit tr, input bit gap);
    bit e_tvalid, e_fire, e_rinc, popped;
    @(negedge clk);
    rst          = rs;
    bus.I_tready = tr;
    bus.I_rempty = gap || (fifo_q.size() == 0);
    #1;
    e_tvalid = (held_q.size() != 0);
    e_fire   = e_tvalid && tr;
    e_rinc   = !rs && !bus.I_rempty &&
               (int'(held_q.size()) + int'(pend_v) - int'(e_fire) < 2);
    check_eq("rinc", 32'(bus.O_rinc), 32'(e_rinc));
    check_eq("tvalid", 32'(bus.O_tvalid), 32'(e_tvalid));
    check_eq("level", 32'(level), 32'(held_q.size()));
    check_eq("seq_err", 32'(seq_err), 32'(err_m));
    if (e_tvalid) begin
      check_eq("tdata", 32'(bus.O_tdata), 32'(held_q[0]));
      check_eq("tlast", 32'(bus.O_tlast), 32'(beat == FL - 1));
    end else begin
      check_eq("tlast_idle", 32'(bus.O_tlast), 32'd0);
    end
    if (bus.O_rinc) begin
      if (rinc_first < 0) rinc_first = cyc;
      rinc_last = cyc; rinc_cnt++;
    end
    if (bus.O_tvalid) begin
      if (tv_first < 0) tv_first = cyc;
      tv_last = cyc; tv_cnt++;
    end
    if (e_fire) begin
      fires++;
      $display("beat %0d tdata %0h tlast %0b", beat, bus.O_tdata, bus.O_tlast);
    end
    popped = bus.O_rinc && !bus.I_rempty;
    @(posedge clk);
    #1;
    if (rs) begin
      held_q.delete();
      pend_v = 1'b0; beat = 0; exp_seq = 8'd1; err_m = 1'b0;
    end else begin
      if (e_fire) begin
        void'(held_q.pop_front());
        beat = (beat + 1) % FL;
      end
      if (pend_v) begin
        if (SEQ_EN && pend_w != exp_seq) err_m = 1'b1;
        exp_seq = pend_w + 8'd1;
        held_q.push_back(pend_w);
      end
      pend_v = popped;
    end
    if (popped) begin
      bus.I_rdata = fifo_q.pop_front();
      pend_w      = bus.I_rdata;
    end
    cyc++;
  endtask

  task automatic push_range(input int first, input int last);
    for (int v = first; v <= last; v++) fifo_q.push_back(8'(v));
  endtask

  initial begin
    rst = 1'b1; bus.I_tready = 1'b0; bus.I_rempty = 1'b1; bus.I_rdata = '0;
    pend_v = 1'b0; pend_w = '0; beat = 0; exp_seq = 8'd1; err_m = 1'b0; cyc = 0;
    clear_stats();
    repeat (2) @(posedge clk);

    // Reset held with a non-empty FIFO
    push_range(1, 30);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rst_tdata", 32'(bus.O_tdata), 32'd0);

    // Full-rate streaming of 30 words
    clear_stats();
    repeat (36) cycle(1'b0, 1'b1, 1'b0);
    check_eq("stream_rinc_cnt", 32'(rinc_cnt), 32'd30);
    check_eq("stream_rinc_span", 32'(rinc_last - rinc_first), 32'd29);
    check_eq("stream_tv_cnt", 32'(tv_cnt), 32'd30);
    check_eq("stream_tv_span", 32'(tv_last - tv_first), 32'd29);
    check_eq("stream_latency", 32'(tv_first - rinc_first), 32'd2);

    // Backpressure from the start
    cycle(1'b1, 1'b0, 1'b0);
    push_range(1, 10);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    check_eq("bp_pops", 32'(10 - fifo_q.size()), 32'd2);
    check_eq("bp_level", 32'(level), 32'd2);
    check_eq("bp_head", 32'(bus.O_tdata), 32'd1);
    clear_stats();
    repeat (16) cycle(1'b0, 1'b1, 1'b0);
    check_eq("bp_drain", 32'(fires), 32'd10);

    // Empty gap mid-frame
    cycle(1'b1, 1'b0, 1'b0);
    push_range(1, 5);
    repeat (7) cycle(1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0);
    push_range(6, 9);
    repeat (8) cycle(1'b0, 1'b1, 1'b0);

    // Reset mid-frame with a pop in flight
    cycle(1'b1, 1'b0, 1'b0);
    push_range(1, 20);
    clear_stats();
    for (int i = 0; i < 20 && fires < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    check_eq("mid_fires", 32'(fires), 32'd3);
    cycle(1'b1, 1'b1, 1'b0);
    clear_stats();
    repeat (22) cycle(1'b0, 1'b1, 1'b0);

    // Sequence fault pattern 1,2,3,5,6
    cycle(1'b1, 1'b0, 1'b0);
    fifo_q.delete();
    fifo_q.push_back(8'd1); fifo_q.push_back(8'd2); fifo_q.push_back(8'd3);
    fifo_q.push_back(8'd5); fifo_q.push_back(8'd6);
    repeat (10) cycle(1'b0, 1'b1, 1'b0);
    check_eq("seq_final", 32'(seq_err), 32'(SEQ_EN));

    // Random traffic
    cycle(1'b1, 1'b0, 1'b0);
    fifo_q.delete();
    next_word = 8'd1;
    for (int i = 0; i < 3000; i++) begin
      int pready;
      bit rs_r;
      pready = 20 + 30 * ((i / 250) % 3);
      if ($urandom_range(0, 99) < 60) begin
        fifo_q.push_back(next_word);
        next_word = next_word + 8'd1;
      end
      rs_r = ($urandom_range(0, 399) == 0);
      cycle(rs_r, $urandom_range(0, 99) < pready, $urandom_range(0, 99) < 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
